// File: rtl/axis_stream_pair_checker.sv
// AXI4-Stream traffic pair: an LFSR-driven master, a slave whose tready
// oscillates, and a scoreboard that matches received beats against sent ones.
module axis_stream_pair_checker #(
    parameter int unsigned TDATA_WIDTH = 8,
    parameter int unsigned LOW_TIME    = 2,
    parameter int unsigned HIGH_TIME   = 6,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   start,
    input  logic [CNT_WIDTH-1:0]   num_xfers,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   comparison_cnt,
    output logic [CNT_WIDTH-1:0]   error_cnt,
    output logic                   sb_overflow
);

    localparam int unsigned PERIOD = LOW_TIME + HIGH_TIME;
    localparam int unsigned PH_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [CNT_WIDTH-1:0]   cmp_cnt_q, cmp_cnt_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic                   ovf_q, ovf_d;
    logic [TDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic m_hs;
    logic s_hs;
    logic fifo_empty;
    logic fifo_full;
    logic push_en;
    logic pop_en;
    logic mismatch;

    assign m_axis_tvalid  = (state_q == ST_SEND);
    assign m_axis_tdata   = lfsr_q[TDATA_WIDTH-1:0];
    assign s_axis_tready  = (phase_q >= PH_W'(LOW_TIME));
    assign busy           = busy_q;
    assign done           = done_q;
    assign comparison_cnt = cmp_cnt_q;
    assign error_cnt      = err_cnt_q;
    assign sb_overflow    = ovf_q;

    assign m_hs       = m_axis_tvalid & m_axis_tready;
    assign s_hs       = s_axis_tvalid & s_axis_tready;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));

    // Master FSM: run control, LFSR advance and done/busy bookkeeping
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        lfsr_d      = lfsr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        case (state_q)
            ST_IDLE: begin
                if (busy_q) begin
                    // run finished sending; hold busy until the scoreboard drains
                    if (fifo_empty) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end else if (start) begin
                    remaining_d = num_xfers;
                    if (num_xfers == '0) begin
                        done_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (m_hs) begin
                    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Free-running tready phase counter
    always_comb begin
        phase_d = (phase_q == PH_W'(PERIOD - 1)) ? '0 : phase_q + PH_W'(1);
    end

    // Scoreboard: FIFO control, bypass compare, saturating statistics
    always_comb begin
        push_en   = 1'b0;
        pop_en    = 1'b0;
        mismatch  = 1'b0;
        ovf_d     = ovf_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cmp_cnt_d = cmp_cnt_q;
        err_cnt_d = err_cnt_q;

        if (s_hs) begin
            if (!fifo_empty) begin
                pop_en   = 1'b1;
                mismatch = (s_axis_tdata != mem_q[rd_ptr_q]);
            end else if (m_hs) begin
                mismatch = (s_axis_tdata != m_axis_tdata);
            end else begin
                mismatch = 1'b1;
            end
        end

        // a bypassed beat is consumed directly and never enters the FIFO
        if (m_hs && !(fifo_empty && s_hs)) begin
            if (!fifo_full || pop_en) begin
                push_en = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);

        if (s_hs && (cmp_cnt_q != '1))     cmp_cnt_d = cmp_cnt_q + CNT_WIDTH'(1);
        if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end

    // State registers with synchronous reset
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            lfsr_q      <= LFSR_SEED;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            phase_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmp_cnt_q   <= '0;
            err_cnt_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            lfsr_q      <= lfsr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmp_cnt_q   <= cmp_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    // Expected-data storage; contents are invalidated by the pointer reset
    always_ff @(posedge aclk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= m_axis_tdata;
        end
    end

endmodule

// File: tb/tb_axis_stream_pair_checker.sv
// Bench for axis_stream_pair_checker: LFSR reference model feeds an expected
// queue at run start; a monitor pops and compares on every master handshake.
module tb_axis_stream_pair_checker;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_xfers = '0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        busy;
    logic        done;
    logic [15:0] comparison_cnt;
    logic [15:0] error_cnt;
    logic        sb_overflow;

    // bench-side wiring control
    logic        mode_stall = 1'b0;
    logic        corrupt_en = 1'b0;
    int          corrupt_at = 0;
    int          hs_total = 0;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp_lfsr = SEED;
    int          exp_cmp = 0;
    int          exp_err = 0;

    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [7:0]  prev_d = '0;

    assign m_axis_tready = mode_stall ? 1'b1 : s_axis_tready;
    assign s_axis_tvalid = mode_stall ? 1'b0 : m_axis_tvalid;
    assign s_axis_tdata  = m_axis_tdata ^ ((corrupt_en && (hs_total == corrupt_at)) ? 8'h01 : 8'h00);

    axis_stream_pair_checker #(
        .TDATA_WIDTH(8),
        .LOW_TIME(2),
        .HIGH_TIME(6),
        .LFSR_SEED(SEED),
        .FIFO_DEPTH(16),
        .CNT_WIDTH(16)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .start(start),
        .num_xfers(num_xfers),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .busy(busy),
        .done(done),
        .comparison_cnt(comparison_cnt),
        .error_cnt(error_cnt),
        .sb_overflow(sb_overflow)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always @(posedge aclk) begin
        if (m_axis_tvalid && m_axis_tready) hs_total <= hs_total + 1;
    end

    // Monitor: master beats against the expected queue, plus AXI hold rules
    always @(negedge aclk) begin
        if (areset) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", m_axis_tvalid, 1);
                chk("hold_data", m_axis_tdata, prev_d);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) chk("extra_beat", m_axis_tvalid, 0);
                else chk("tdata", m_axis_tdata, exp_q.pop_front());
            end
            prev_v = m_axis_tvalid;
            prev_r = m_axis_tready;
            prev_d = m_axis_tdata;
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic run_xfers(input int n, input bit corrupt);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_lfsr[7:0]);
            exp_lfsr = lfsr_next(exp_lfsr);
        end
        if (corrupt) begin
            corrupt_at = hs_total + 2;
            corrupt_en = 1'b1;
        end
        num_xfers = 16'(n);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic finish_run(input int n, input bit corrupt);
        int k = 0;
        while (!done && k < 500) begin
            cyc();
            k++;
        end
        chk("done", done, 1);
        corrupt_en = 1'b0;
        exp_cmp += n;
        exp_err += corrupt ? 1 : 0;
        chk("cmp_cnt", comparison_cnt, exp_cmp);
        chk("err_cnt", error_cnt, exp_err);
        chk("q_left", exp_q.size(), 0);
        chk("busy_end", busy, 0);
    endtask

    task automatic wait_hs(input int target);
        int k = 0;
        while (hs_total < target && k < 200) begin
            cyc();
            k++;
        end
        chk("hs_reached", (hs_total >= target) ? 1 : 0, 1);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_lfsr = SEED;
        exp_cmp = 0;
        exp_err = 0;
    endtask

    task automatic chk_reset_values();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmp", comparison_cnt, 0);
        chk("rst_err", error_cnt, 0);
        chk("rst_ovf", sb_overflow, 0);
        chk("rst_tdata", m_axis_tdata, 8'hE1);
    endtask

    initial begin
        int base;

        // reset and tready oscillation pattern
        repeat (3) @(posedge aclk);
        #1;
        chk_reset_values();
        areset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("tready_pat", s_axis_tready, (i >= 2 && i < 8) ? 1 : 0);
            cyc();
        end

        // single beat loopback
        run_xfers(1, 1'b0);
        chk("t2_tvalid", m_axis_tvalid, 1);
        chk("t2_tdata", m_axis_tdata, 8'hE1);
        chk("t2_busy", busy, 1);
        chk("t2_done", done, 0);
        finish_run(1, 1'b0);
        chk("t2_cmp1", comparison_cnt, 1);

        // back-to-back runs, sequence continues across runs
        for (int r = 0; r < 4; r++) begin
            run_xfers(1, 1'b0);
            finish_run(1, 1'b0);
        end
        run_xfers(2, 1'b0);
        finish_run(2, 1'b0);
        chk("t3_cmp7", comparison_cnt, 7);

        // third beat of a 5-beat run corrupted on the slave side
        run_xfers(5, 1'b1);
        finish_run(5, 1'b1);
        chk("t4_err1", error_cnt, 1);
        chk("t4_cmp12", comparison_cnt, 12);

        // zero-length run
        run_xfers(0, 1'b0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_tvalid", m_axis_tvalid, 0);
        repeat (5) cyc();
        chk("zero_cmp", comparison_cnt, exp_cmp);

        // stalled sink: scoreboard fills and overflows on the 17th push
        mode_stall = 1'b1;
        base = hs_total;
        run_xfers(20, 1'b0);
        wait_hs(base + 16);
        chk("ovf_at16", sb_overflow, 0);
        wait_hs(base + 17);
        chk("ovf_at17", sb_overflow, 1);
        wait_hs(base + 20);
        cyc();
        chk("ovf_q_left", exp_q.size(), 0);
        chk("ovf_busy", busy, 1);
        chk("ovf_done", done, 0);
        chk("ovf_cmp", comparison_cnt, exp_cmp);

        // reset to clear, then abandon a 10-beat run after 3 beats
        mode_stall = 1'b0;
        areset = 1'b1;
        model_reset();
        cyc();
        areset = 1'b0;
        base = hs_total;
        run_xfers(10, 1'b0);
        wait_hs(base + 3);
        areset = 1'b1;
        model_reset();
        cyc();
        chk_reset_values();
        areset = 1'b0;
        run_xfers(1, 1'b0);
        finish_run(1, 1'b0);
        chk("t6_err0", error_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
